// File: rtl/i2c_sequencer.sv
// i2c_sequencer: walks an instruction ROM from address 0 and issues I2C read/write transactions
//
// Each ROM word is op[31:24] | dev[23:16] | reg[15:8] | data[7:0].
// Opcodes: 0x00 NOP, 0x01 read, 0x02 write; any other value aborts the run.
//
// Ports:
//   clk_i, reset_n_i          clock, asynchronous active-low reset
//   start_i                   one-cycle pulse, begins a run at address 0 (accepted only in IDLE)
//   mem_addr_o                ROM address (the program counter)
//   mem_data_i, mem_error_i   registered ROM word and error code, valid one cycle after mem_addr_o
//   i2c_req_o .. i2c_wdata_o  transaction request and its fields to the I2C master
//   i2c_ack_i                 master accepted the request
//   i2c_done_i, i2c_nack_i    transaction finished, slave NACK qualifier
//   i2c_rdata_i               read byte, valid with i2c_done_i
//   rd_data_o, rd_valid_o     last read byte and its one-cycle update strobe
//   busy_o, done_o            run in progress, one-cycle end-of-run pulse
//   err_code_o                0 ok, 1 bad ROM address, 2 illegal op, 3 NACK, 4 timeout
//
// Optional: define I2C_SEQ_TIMEOUT_EN to abort a transaction that stays in
// REQ/RESP until its 16-bit cycle counter reaches 16'hFFFF.
module i2c_sequencer #(
    parameter int ADDR_WIDTH = 8,
    parameter int PROG_LEN   = 2
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic                  start_i,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic [31:0]           mem_data_i,
    input  logic [3:0]            mem_error_i,
    output logic                  i2c_req_o,
    output logic                  i2c_rw_o,
    output logic [7:0]            i2c_dev_o,
    output logic [7:0]            i2c_reg_o,
    output logic [7:0]            i2c_wdata_o,
    input  logic                  i2c_ack_i,
    input  logic                  i2c_done_i,
    input  logic                  i2c_nack_i,
    input  logic [7:0]            i2c_rdata_i,
    output logic [7:0]            rd_data_o,
    output logic                  rd_valid_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [3:0]            err_code_o
);
    typedef enum logic [2:0] {IDLE, FETCH, WAIT, DECODE, REQ, RESP, NEXT, FINISH} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(PROG_LEN - 1);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  req_q, req_d;
    logic                  rw_q, rw_d;
    logic [7:0]            dev_q, dev_d;
    logic [7:0]            reg_q, reg_d;
    logic [7:0]            wdata_q, wdata_d;
    logic [7:0]            rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [3:0]            err_q, err_d;
`ifdef I2C_SEQ_TIMEOUT_EN
    logic [15:0]           cnt_q, cnt_d;
`endif

    logic [7:0] op;
    assign op = mem_data_i[31:24];

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_d      = req_q;
        rw_d       = rw_q;
        dev_d      = dev_q;
        reg_d      = reg_q;
        wdata_d    = wdata_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        err_d      = err_q;
`ifdef I2C_SEQ_TIMEOUT_EN
        cnt_d      = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    pc_d    = '0;
                    err_d   = 4'd0;
                    state_d = FETCH;
                end
            end
            FETCH:  state_d = WAIT;
            WAIT:   state_d = DECODE;
            DECODE: begin
                if (mem_error_i != 4'd0) begin
                    err_d   = 4'd1;
                    state_d = FINISH;
                end else if (op == 8'h00) begin
                    state_d = NEXT;
                end else if (op == 8'h01 || op == 8'h02) begin
                    rw_d    = (op == 8'h01);
                    dev_d   = mem_data_i[23:16];
                    reg_d   = mem_data_i[15:8];
                    wdata_d = mem_data_i[7:0];
                    req_d   = 1'b1;
                    state_d = REQ;
`ifdef I2C_SEQ_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end else begin
                    err_d   = 4'd2;
                    state_d = FINISH;
                end
            end
            REQ, RESP: begin
`ifdef I2C_SEQ_TIMEOUT_EN
                cnt_d = cnt_q + 16'd1;
`endif
                // done in REQ counts as ack+done, with or without ack
                if (i2c_done_i) begin
                    req_d      = 1'b0;
                    state_d    = i2c_nack_i ? FINISH : NEXT;
                    err_d      = i2c_nack_i ? 4'd3 : err_q;
                    rd_valid_d = !i2c_nack_i && rw_q;
                    rd_data_d  = (!i2c_nack_i && rw_q) ? i2c_rdata_i : rd_data_q;
                end else if (state_q == REQ && i2c_ack_i) begin
                    req_d   = 1'b0;
                    state_d = RESP;
                end
`ifdef I2C_SEQ_TIMEOUT_EN
                else if (&cnt_d) begin
                    req_d   = 1'b0;
                    err_d   = 4'd4;
                    state_d = FINISH;
                end
`endif
            end
            NEXT: begin
                if (pc_q == LAST) begin
                    state_d = FINISH;
                end else begin
                    pc_d    = pc_q + ADDR_WIDTH'(1);
                    state_d = FETCH;
                end
            end
            FINISH: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= IDLE;
            pc_q       <= '0;
            req_q      <= 1'b0;
            rw_q       <= 1'b0;
            dev_q      <= '0;
            reg_q      <= '0;
            wdata_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            err_q      <= '0;
`ifdef I2C_SEQ_TIMEOUT_EN
            cnt_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_q      <= req_d;
            rw_q       <= rw_d;
            dev_q      <= dev_d;
            reg_q      <= reg_d;
            wdata_q    <= wdata_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            err_q      <= err_d;
`ifdef I2C_SEQ_TIMEOUT_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

    assign mem_addr_o  = pc_q;
    assign i2c_req_o   = req_q;
    assign i2c_rw_o    = rw_q;
    assign i2c_dev_o   = dev_q;
    assign i2c_reg_o   = reg_q;
    assign i2c_wdata_o = wdata_q;
    assign rd_data_o   = rd_data_q;
    assign rd_valid_o  = rd_valid_q;
    assign busy_o      = state_q != IDLE;
    assign done_o      = state_q == FINISH;
    assign err_code_o  = err_q;
endmodule

// File: tb/tb_i2c_sequencer.sv
// tb_i2c_sequencer: directed checks of i2c_sequencer with PROG_LEN 1, 2 and 3 instances
module tb_i2c_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [2:0] st = '0;
    logic [2:0][7:0] maddr;
    logic [31:0] mdata [3];
    logic [3:0] merr [3];
    logic ack = 1'b0, dn = 1'b0, nack = 1'b0;
    logic [7:0] rdata = '0;
    logic [2:0] req, rw, rdv, busy, dne;
    logic [7:0] dev [3], rgs [3], wd [3], rdd [3];
    logic [3:0] err [3];
    logic [31:0] rom [4] = '{default: 32'd0};
    int romlen = 4;
    int n_chk = 0, n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : gd
        i2c_sequencer #(.ADDR_WIDTH(8), .PROG_LEN(g + 1)) u_dut (
            .clk_i(clk), .reset_n_i(rst_n), .start_i(st[g]),
            .mem_addr_o(maddr[g]), .mem_data_i(mdata[g]), .mem_error_i(merr[g]),
            .i2c_req_o(req[g]), .i2c_rw_o(rw[g]), .i2c_dev_o(dev[g]), .i2c_reg_o(rgs[g]),
            .i2c_wdata_o(wd[g]), .i2c_ack_i(ack), .i2c_done_i(dn), .i2c_nack_i(nack),
            .i2c_rdata_i(rdata), .rd_data_o(rdd[g]), .rd_valid_o(rdv[g]), .busy_o(busy[g]),
            .done_o(dne[g]), .err_code_o(err[g])
        );
    end

    // registered ROM per instance; addresses at or beyond romlen report error 1
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            mdata[i] <= rom[maddr[i][1:0]];
            merr[i]  <= (int'(maddr[i]) >= romlen) ? 4'd1 : 4'd0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; st = '0; ack = 1'b0; dn = 1'b0; nack = 1'b0; rdata = '0;
        ticks(2);
        rst_n = 1'b1;
        ticks(1);
    endtask

    task automatic do_start(input int g);
        st[g] = 1'b1;
        ticks(1);
        st[g] = 1'b0;
    endtask

    int n;

    initial begin
        // reset values
        ticks(1);
        chk("rst_req", 32'(req[1]), 0);
        chk("rst_busy", 32'(busy[1]), 0);
        chk("rst_done", 32'(dne[1]), 0);
        chk("rst_err", 32'(err[1]), 0);
        chk("rst_rdd", 32'(rdd[1]), 0);
        chk("rst_addr", 32'(maddr[1]), 0);

        // read then write, PROG_LEN=2
        rom[0] = 32'h0100f000; rom[1] = 32'h021dab32; romlen = 2;
        do_reset();
        do_start(1);
        chk("t1_busy", 32'(busy[1]), 1);
        ticks(2);
        chk("t1_req_early", 32'(req[1]), 0);
        ticks(1);
        chk("t1_req", 32'(req[1]), 1);
        chk("t1_rw", 32'(rw[1]), 1);
        chk("t1_dev", 32'(dev[1]), 32'h00);
        chk("t1_reg", 32'(rgs[1]), 32'hf0);
        ticks(2);
        chk("t1_req_hold", 32'(req[1]), 1);
        ack = 1'b1;
        ticks(1);
        ack = 1'b0;
        chk("t1_req_drop", 32'(req[1]), 0);
        ticks(1);
        dn = 1'b1; rdata = 8'h5a;
        ticks(1);
        dn = 1'b0; rdata = 8'h00;
        chk("t1_rdv", 32'(rdv[1]), 1);
        chk("t1_rdd", 32'(rdd[1]), 32'h5a);
        ticks(1);
        chk("t1_rdv_pulse", 32'(rdv[1]), 0);
        ticks(3);
        chk("t1_req2", 32'(req[1]), 1);
        chk("t1_rw2", 32'(rw[1]), 0);
        chk("t1_dev2", 32'(dev[1]), 32'h1d);
        chk("t1_reg2", 32'(rgs[1]), 32'hab);
        chk("t1_wd2", 32'(wd[1]), 32'h32);
        chk("t1_addr2", 32'(maddr[1]), 1);
        ack = 1'b1; dn = 1'b1;
        ticks(1);
        ack = 1'b0; dn = 1'b0;
        chk("t1_req2_drop", 32'(req[1]), 0);
        chk("t1_wr_no_rdv", 32'(rdv[1]), 0);
        chk("t1_rdd_keep", 32'(rdd[1]), 32'h5a);
        chk("t1_done_early", 32'(dne[1]), 0);
        ticks(1);
        chk("t1_done", 32'(dne[1]), 1);
        chk("t1_err", 32'(err[1]), 0);
        ticks(1);
        chk("t1_done_pulse", 32'(dne[1]), 0);
        chk("t1_idle", 32'(busy[1]), 0);

        // NOP, PROG_LEN=1: done 4 cycles after start; start during FINISH ignored
        rom[0] = 32'h00000000; romlen = 1;
        do_reset();
        do_start(0);
        chk("t2_busy", 32'(busy[0]), 1);
        ticks(3);
        chk("t2_done_early", 32'(dne[0]), 0);
        chk("t2_no_req", 32'(req[0]), 0);
        ticks(1);
        chk("t2_done", 32'(dne[0]), 1);
        chk("t2_err", 32'(err[0]), 0);
        st[0] = 1'b1;
        ticks(1);
        st[0] = 1'b0;
        chk("t2_start_in_finish", 32'(busy[0]), 0);

        // illegal opcode; err holds, clears on next start
        rom[0] = 32'h07000000; romlen = 2;
        do_reset();
        do_start(1);
        ticks(3);
        chk("t3_done", 32'(dne[1]), 1);
        chk("t3_err", 32'(err[1]), 2);
        chk("t3_no_req", 32'(req[1]), 0);
        ticks(1);
        chk("t3_err_hold", 32'(err[1]), 2);
        do_start(1);
        chk("t3_err_clear", 32'(err[1]), 0);
        ticks(3);
        chk("t3_err_again", 32'(err[1]), 2);

        // NACK on write aborts; done outside REQ/RESP ignored
        rom[0] = 32'h02112233; rom[1] = 32'h01445566; romlen = 2;
        do_reset();
        do_start(1);
        ticks(1);
        dn = 1'b1; nack = 1'b1;
        ticks(1);
        dn = 1'b0; nack = 1'b0;
        chk("t4_stray_done", 32'(dne[1]), 0);
        ticks(1);
        chk("t4_req", 32'(req[1]), 1);
        chk("t4_rw", 32'(rw[1]), 0);
        chk("t4_wd", 32'(wd[1]), 32'h33);
        ack = 1'b1;
        ticks(1);
        ack = 1'b0;
        dn = 1'b1; nack = 1'b1;
        ticks(1);
        dn = 1'b0; nack = 1'b0;
        chk("t4_done", 32'(dne[1]), 1);
        chk("t4_err", 32'(err[1]), 3);
        ticks(1);
        chk("t4_addr", 32'(maddr[1]), 0);
        chk("t4_idle", 32'(busy[1]), 0);

        // PROG_LEN=3, bad ROM address 2
        rom[0] = 32'h01223344; rom[1] = 32'h02556677; romlen = 2;
        do_reset();
        do_start(2);
        ticks(3);
        chk("t5_req", 32'(req[2]), 1);
        chk("t5_dev", 32'(dev[2]), 32'h22);
        chk("t5_reg", 32'(rgs[2]), 32'h33);
        ack = 1'b1; dn = 1'b1; rdata = 8'ha5;
        ticks(1);
        ack = 1'b0; dn = 1'b0; rdata = 8'h00;
        chk("t5_rdv", 32'(rdv[2]), 1);
        chk("t5_rdd", 32'(rdd[2]), 32'ha5);
        ticks(4);
        chk("t5_req2", 32'(req[2]), 1);
        chk("t5_dev2", 32'(dev[2]), 32'h55);
        chk("t5_wd2", 32'(wd[2]), 32'h77);
        dn = 1'b1;
        ticks(1);
        dn = 1'b0;
        chk("t5_req2_drop", 32'(req[2]), 0);
        chk("t5_busy", 32'(busy[2]), 1);
        ticks(3);
        chk("t5_addr", 32'(maddr[2]), 2);
        chk("t5_done_early", 32'(dne[2]), 0);
        ticks(1);
        chk("t5_done", 32'(dne[2]), 1);
        chk("t5_err", 32'(err[2]), 1);

        // start during RESP ignored; reset during REQ is immediate
        rom[0] = 32'h01aabbcc; rom[1] = 32'h02000000; romlen = 2;
        do_reset();
        do_start(1);
        ticks(3);
        ack = 1'b1;
        ticks(1);
        ack = 1'b0;
        st[1] = 1'b1;
        ticks(1);
        st[1] = 1'b0;
        chk("t6_busy", 32'(busy[1]), 1);
        dn = 1'b1; rdata = 8'h3c;
        ticks(1);
        dn = 1'b0; rdata = 8'h00;
        chk("t6_rdd", 32'(rdd[1]), 32'h3c);
        ticks(1);
        chk("t6_addr", 32'(maddr[1]), 1);
        ticks(3);
        chk("t6_req", 32'(req[1]), 1);
        rst_n = 1'b0;
        #1;
        chk("t6_async_req", 32'(req[1]), 0);
        chk("t6_async_busy", 32'(busy[1]), 0);
        ticks(1);
        rst_n = 1'b1;

`ifdef I2C_SEQ_TIMEOUT_EN
        // no ack: abort after 65535 cycles in REQ, late done ignored, then a normal run
        rom[0] = 32'h02010203; rom[1] = 32'h00000000; romlen = 2;
        do_reset();
        do_start(1);
        ticks(3);
        chk("t7_req", 32'(req[1]), 1);
        n = 0;
        while (req[1] && n < 70000) begin
            ticks(1);
            n++;
        end
        chk("t7_cycles", 32'(n), 65535);
        chk("t7_done", 32'(dne[1]), 1);
        chk("t7_err", 32'(err[1]), 4);
        ticks(1);
        dn = 1'b1;
        ticks(1);
        dn = 1'b0;
        chk("t7_late_done", 32'(busy[1]), 0);
        chk("t7_err_hold", 32'(err[1]), 4);
        do_start(1);
        ticks(3);
        ack = 1'b1; dn = 1'b1;
        ticks(1);
        ack = 1'b0; dn = 1'b0;
        ticks(5);
        chk("t7_rerun_done", 32'(dne[1]), 1);
        chk("t7_rerun_err", 32'(err[1]), 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/i2c_sequencer.md
Name: i2c_sequencer

Overview:
- Steps through the instruction ROM (`register_memory`) from address 0.
- Decodes each 32-bit word, formatted as op[31:24] | dev[23:16] | reg[15:8] | data[7:0].
- Issues I2C read/write transactions to the I2C master over a req/ack/done handshake.
- Sits between the ROM and the I2C master; returns read bytes toward the 7-seg datapath.

Parameters:
- ADDR_WIDTH, 8, width of mem_addr.
- PROG_LEN, 2, number of instructions executed per run; address PROG_LEN-1 is the last one.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a run at address 0
- mem_addr  out  ADDR_WIDTH  ROM address
- mem_data  in  32  ROM read_data; registered, valid 1 cycle after mem_addr
- mem_error  in  4  ROM error_code; nonzero = invalid address
- i2c_req  out  1  transaction request
- i2c_rw  out  1  1 = read, 0 = write
- i2c_dev  out  8  device address
- i2c_reg  out  8  register address
- i2c_wdata  out  8  write byte
- i2c_ack  in  1  master accepted request
- i2c_done  in  1  one-cycle pulse; transaction finished
- i2c_nack  in  1  qualifies i2c_done; slave NACK
- i2c_rdata  in  8  read byte, valid with i2c_done
- rd_data  out  8  last read byte
- rd_valid  out  1  one-cycle pulse when rd_data updates
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at end of run (normal or abort)
- err_code  out  4  0 ok, 1 bad ROM address, 2 illegal op, 3 NACK, 4 timeout

Behaviour:
- Reset values: all outputs 0; state IDLE; internal program counter pc = 0.
- States:
  - IDLE: busy=0. start -> pc=0, err_code=0, go to FETCH.
  - FETCH: mem_addr=pc. Next cycle -> WAIT.
  - WAIT: ROM registers the word. Next cycle -> DECODE.
  - DECODE: sample mem_data and mem_error.
    - mem_error != 0 -> err_code=1, go to FINISH.
    - op 0x00 (NOP) -> go to NEXT.
    - op 0x01 or 0x02 -> latch dev/reg/data into i2c_* outputs; i2c_rw = (op==0x01); i2c_req=1; go to REQ.
    - any other op -> err_code=2, go to FINISH.
  - REQ: i2c_req and all i2c_* fields held stable until i2c_ack=1 is sampled; then i2c_req=0 in the next cycle, go to RESP.
  - RESP: wait for i2c_done.
    - i2c_done with i2c_nack=1 -> err_code=3, go to FINISH.
    - i2c_done with i2c_nack=0 -> if read, rd_data=i2c_rdata and rd_valid pulses next cycle; go to NEXT.
  - NEXT: if pc == PROG_LEN-1 -> FINISH; else pc=pc+1, go to FETCH.
  - FINISH: done=1 for one cycle; -> IDLE.
- busy=1 in every state except IDLE.
- Latency:
  - NOP: 4 cycles (FETCH, WAIT, DECODE, NEXT).
  - start to first i2c_req: 3 cycles.
- Boundary conditions:
  - start while busy: ignored.
  - start in the same cycle as FINISH: ignored; a new start must arrive in IDLE.
  - i2c_ack and i2c_done in the same cycle: valid; treated as ack followed by immediate done, so REQ goes directly to NEXT or FINISH.
  - i2c_done in REQ without ack: treated as a combined ack+done; same outcome as above.
  - i2c_done outside REQ/RESP: ignored.
  - pc width is ADDR_WIDTH and never wraps past PROG_LEN-1.
  - PROG_LEN=1: runs the single instruction at address 0, then finishes.
- err_code and rd_data hold their values until the next accepted start (err_code clears to 0 on start; rd_data keeps its old value).
- Reset mid-run: asynchronous return to IDLE; i2c_req drops immediately.

Optional Feature:
- Macro: I2C_SEQ_TIMEOUT_EN.
- Defined:
  - A 16-bit counter runs in REQ and RESP and clears on each entry to REQ.
  - Reaching 16'hFFFF before completion -> i2c_req=0, err_code=4, go to FINISH.
  - A late i2c_done after abort is ignored.
- Undefined: no counter; the sequencer waits indefinitely; err_code 4 is never produced.

Test Plan:
- Program {0x0100f000, 0x021dab32}, PROG_LEN=2, master acks after 2 cycles, done with rdata=0x5A:
  - Read of dev 0x00 reg 0xf0, rd_data=0x5A with rd_valid pulse.
  - Write dev 0x1d reg 0xab wdata 0x32 with i2c_rw=0.
  - done pulse, err_code=0.
- Word 0x00000000 at address 0, PROG_LEN=1:
  - No i2c_req.
  - done exactly 4 cycles after start, err_code=0.
- Word 0x07000000:
  - No i2c_req.
  - done pulse, err_code=2.
- Write instruction, i2c_done with i2c_nack=1:
  - Run aborts, err_code=3.
  - The following instruction is not fetched (mem_addr stays 0).
- PROG_LEN=3 with ROM returning mem_error=1 at address 2:
  - Two transactions complete, then err_code=1 and done.
- start pulsed during RESP: no effect. reset_n low during REQ: i2c_req=0, busy=0 asynchronously.
- With I2C_SEQ_TIMEOUT_EN defined, ack never asserted:
  - err_code=4 after 65535 cycles in REQ.
  - Subsequent start runs normally.
